// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU arbiter slice.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int CMD_W  = 4;
    localparam int RES_W  = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] opa;
        logic [DATA_W-1:0] opb;
        logic              cin;
        logic              mode;
        logic [CMD_W-1:0]  cmd;
    } alu_req_t;

    typedef struct packed {
        logic oflow;
        logic cout;
        logic g;
        logic e;
        logic l;
        logic err;
    } alu_flags_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signals of the arbiter; slave is the arbiter's view.
interface alu_arbiter_if import alu_pkg::*; #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*DATA_W-1:0] req_opa;
    logic [NREQ*DATA_W-1:0] req_opb;
    logic [NREQ-1:0]        req_cin;
    logic [NREQ-1:0]        req_mode;
    logic [NREQ*CMD_W-1:0]  req_cmd;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [2:0]             rsp_id;
    logic [RES_W-1:0]       rsp_res;
    logic [5:0]             rsp_flags;

    logic [DATA_W-1:0]      alu_opa;
    logic [DATA_W-1:0]      alu_opb;
    logic                   alu_cin;
    logic                   alu_ce;
    logic                   alu_mode;
    logic [CMD_W-1:0]       alu_cmd;

    logic [RES_W-1:0]       alu_res;
    logic                   alu_oflow;
    logic                   alu_cout;
    logic                   alu_g;
    logic                   alu_e;
    logic                   alu_l;
    logic                   alu_err;

    modport slave (
        input  req_valid, req_opa, req_opb, req_cin, req_mode, req_cmd, rsp_ready,
        input  alu_res, alu_oflow, alu_cout, alu_g, alu_e, alu_l, alu_err,
        output req_ready, rsp_valid, rsp_id, rsp_res, rsp_flags,
        output alu_opa, alu_opb, alu_cin, alu_ce, alu_mode, alu_cmd
    );

    modport master (
        output req_valid, req_opa, req_opb, req_cin, req_mode, req_cmd, rsp_ready,
        output alu_res, alu_oflow, alu_cout, alu_g, alu_e, alu_l, alu_err,
        input  req_ready, rsp_valid, rsp_id, rsp_res, rsp_flags,
        input  alu_opa, alu_opb, alu_cin, alu_ce, alu_mode, alu_cmd
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin grant: lowest active requester above ptr wins, otherwise wrap to the lowest active one.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);
    logic [NREQ-1:0] above;
    logic [NREQ-1:0] masked;
    logic [NREQ-1:0] pick_m;
    logic [NREQ-1:0] pick_a;

    // ptr = NREQ-1 shifts the marker out entirely, leaving an empty mask
    assign above  = ~((NREQ'(2) << ptr) - NREQ'(1));
    assign masked = req & above;
    assign pick_m = masked & (~masked + NREQ'(1));
    assign pick_a = req & (~req + NREQ'(1));
    assign grant  = (|masked) ? pick_m : pick_a;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters: round-robin grant, one-cycle issue, fixed-latency wait, held response.
module alu_arbiter import alu_pkg::*; #(
    parameter int NREQ    = 4,
    parameter int ALU_LAT = 1
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);
    // state | meaning
    // IDLE  | nothing in flight; accept the round-robin winner
    // ISSUE | alu_ce high for one cycle with the latched operation
    // WAIT  | count ALU_LAT cycles, capture result and flags on the last
    // RESP  | hold response until rsp_ready; may accept the next request
    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] ISSUE = ST_ISSUE;
    localparam logic [1:0] WAIT  = ST_WAIT;
    localparam logic [1:0] RESP  = ST_RESP;

    localparam int         PW       = $clog2(NREQ);
    localparam logic [1:0] LAT_LOAD = 2'(ALU_LAT - 1);

    logic [1:0]       state;
    logic [1:0]       lat_cnt;
    logic [PW-1:0]    rr_ptr;
    logic [NREQ-1:0]  grant;
    logic [PW-1:0]    grant_idx;
    alu_req_t         sel;
    alu_req_t         cur;
    logic [2:0]       cur_id;
    logic [2:0]       rsp_id_q;
    logic [RES_W-1:0] rsp_res_q;
    alu_flags_t       rsp_flags_q;
    logic             accept_ok;
    logic             req_xfer;
    logic             rsp_xfer;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    assign rsp_xfer = bus.rsp_valid & bus.rsp_ready;
    // rst gates ready so nothing looks accepted while the block is held in reset
    assign accept_ok     = rst & ((state == IDLE) | ((state == RESP) & bus.rsp_ready));
    assign bus.req_ready = accept_ok ? grant : '0;
    assign req_xfer      = |bus.req_ready;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) grant_idx = PW'(i);
        end
    end

    always_comb begin
        sel.opa  = bus.req_opa[grant_idx*DATA_W +: DATA_W];
        sel.opb  = bus.req_opb[grant_idx*DATA_W +: DATA_W];
        sel.cin  = bus.req_cin[grant_idx];
        sel.mode = bus.req_mode[grant_idx];
        sel.cmd  = bus.req_cmd[grant_idx*CMD_W +: CMD_W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            rr_ptr      <= PW'(NREQ - 1);
            cur         <= '0;
            cur_id      <= '0;
            rsp_id_q    <= '0;
            rsp_res_q   <= '0;
            rsp_flags_q <= '0;
        end else begin
            case (state)
                IDLE: if (req_xfer) state <= ISSUE;
                ISSUE: begin
                    state   <= WAIT;
                    lat_cnt <= LAT_LOAD;
                end
                WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        state       <= RESP;
                        rsp_id_q    <= cur_id;
                        rsp_res_q   <= bus.alu_res;
                        rsp_flags_q <= {bus.alu_oflow, bus.alu_cout, bus.alu_g,
                                        bus.alu_e, bus.alu_l, bus.alu_err};
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                RESP: if (rsp_xfer) state <= req_xfer ? ISSUE : IDLE;
                default: state <= IDLE;
            endcase
            if (req_xfer) begin
                cur    <= sel;
                cur_id <= 3'(grant_idx);
                rr_ptr <= grant_idx;
            end
        end
    end

    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_res   = rsp_res_q;
    assign bus.rsp_flags = rsp_flags_q;

    assign bus.alu_ce   = (state == ISSUE);
    assign bus.alu_opa  = cur.opa;
    assign bus.alu_opb  = cur.opb;
    assign bus.alu_cin  = cur.cin;
    assign bus.alu_mode = cur.mode;
    assign bus.alu_cmd  = cur.cmd;

endmodule

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
// Bench for alu_arbiter (ALU_LAT=3 build): directed vectors, handshake corner cases, randomized scoreboard run.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NREQ    = 4;
    localparam int ALU_LAT = 3;
    localparam int NRAND   = 700;

    typedef struct {
        int         id;
        logic [7:0] opa;
        logic [7:0] opb;
        logic       cin;
        logic       mode;
        logic [3:0] cmd;
        logic [8:0] res;
        logic [5:0] flags;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0]  t_opa  [NREQ];
    logic [7:0]  t_opb  [NREQ];
    logic        t_cin  [NREQ];
    logic        t_mode [NREQ];
    logic [3:0]  t_cmd  [NREQ];
    logic        t_val  [NREQ];
    logic [14:0] alu_pipe [ALU_LAT];

    vec_t        tbl [6];
    int          rr_exp [5] = '{0, 1, 2, 3, 0};
    int          grants[$];
    int          rids[$];
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    alu_arbiter_if #(.NREQ(NREQ)) bus ();

    alu_arbiter #(.NREQ(NREQ), .ALU_LAT(ALU_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference ALU behaviour: {res[8:0], oflow, cout, g, e, l, err}
    function automatic logic [14:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic ci, input logic md, input logic [3:0] c);
        logic [8:0] r;
        logic       ov;
        ov = 1'b0;
        case (c)
            4'h0: begin
                r  = {1'b0, a} + {1'b0, b} + {8'b0, ci};
                ov = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'h1:    r = {1'b0, a} - {1'b0, b};
            default: r = {md, a ^ b};
        endcase
        return {r, ov, r[8], a > b, a == b, a < b, c >= 4'hC};
    endfunction

    // Bench ALU: correct result only exactly ALU_LAT edges after a ce sample, noise otherwise
    always @(posedge clk) begin
        alu_pipe[0] <= bus.alu_ce ? alu_fn(bus.alu_opa, bus.alu_opb, bus.alu_cin, bus.alu_mode, bus.alu_cmd)
                                  : 15'($urandom);
        for (int k = 1; k < ALU_LAT; k++) alu_pipe[k] <= alu_pipe[k-1];
    end
    assign {bus.alu_res, bus.alu_oflow, bus.alu_cout, bus.alu_g, bus.alu_e, bus.alu_l, bus.alu_err}
        = alu_pipe[ALU_LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_bus();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]       = t_val[i];
            bus.req_opa[i*8 +: 8]  = t_opa[i];
            bus.req_opb[i*8 +: 8]  = t_opb[i];
            bus.req_cin[i]         = t_cin[i];
            bus.req_mode[i]        = t_mode[i];
            bus.req_cmd[i*4 +: 4]  = t_cmd[i];
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_res, bus.rsp_flags, bus.alu_ce,
                    bus.alu_opa, bus.alu_opb, bus.alu_cmd, bus.alu_cin, bus.alu_mode});
    endfunction

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic load_all();
        for (int i = 0; i < NREQ; i++) begin
            t_val[i]  = 1'b1;
            t_opa[i]  = 8'(16 * i + 3);
            t_opb[i]  = 8'(i + 1);
            t_cin[i]  = 1'b0;
            t_mode[i] = 1'b0;
            t_cmd[i]  = 4'(i);
        end
        drive_bus();
    endtask

    // Requests held high during reset must not see req_ready
    task automatic do_reset();
        load_all();
        bus.rsp_ready = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_outputs", outs(), 64'd0);
        for (int i = 0; i < NREQ; i++) t_val[i] = 1'b0;
        drive_bus();
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ce_cnt, lat, win, id;
        logic        hold_bad, stale, hold_prev, rsp_x, allowed, quiet;
        logic [NREQ-1:0] acc, exp_rdy;
        logic [17:0] held, snap;

        tbl[0] = '{2, 8'h0F, 8'h01, 1'b0, 1'b0, 4'h0, 9'h010, 6'b001000};
        tbl[1] = '{0, 8'hFF, 8'h01, 1'b0, 1'b0, 4'h0, 9'h100, 6'b011000};
        tbl[2] = '{1, 8'h7F, 8'h01, 1'b1, 1'b0, 4'h0, 9'h081, 6'b101000};
        tbl[3] = '{3, 8'h55, 8'h55, 1'b0, 1'b1, 4'h2, 9'h100, 6'b010100};
        tbl[4] = '{1, 8'h10, 8'h20, 1'b0, 1'b0, 4'h1, 9'h1F0, 6'b010010};
        tbl[5] = '{0, 8'h3C, 8'hA5, 1'b0, 1'b0, 4'hD, 9'h099, 6'b000011};

        do_reset();

        // Directed single requests: grant, latency, single ce pulse, operand hold, response data
        for (int v = 0; v < 6; v++) begin
            @(posedge clk); #1;
            id = tbl[v].id;
            t_val[id] = 1'b1; t_opa[id] = tbl[v].opa; t_opb[id] = tbl[v].opb;
            t_cin[id] = tbl[v].cin; t_mode[id] = tbl[v].mode; t_cmd[id] = tbl[v].cmd;
            drive_bus();
            bus.rsp_ready = 1'b1;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (bus.req_ready[id]) break;
            end
            check("tbl_grant", 64'(bus.req_ready), 64'(NREQ'(1) << id));
            @(posedge clk); #1;
            t_val[id] = 1'b0;
            drive_bus();
            ce_cnt = 0; lat = 0; hold_bad = 1'b0;
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk);
                if (bus.alu_ce) ce_cnt++;
                if (bus.alu_opa !== tbl[v].opa || bus.alu_opb !== tbl[v].opb || bus.alu_cin !== tbl[v].cin ||
                    bus.alu_mode !== tbl[v].mode || bus.alu_cmd !== tbl[v].cmd) hold_bad = 1'b1;
                if (bus.rsp_valid) begin
                    lat = c;
                    break;
                end
            end
            check("tbl_latency", lat, ALU_LAT + 2);
            check("tbl_ce_pulses", ce_cnt, 1);
            check("tbl_alu_hold", hold_bad, 0);
            check("tbl_rsp_id", bus.rsp_id, id);
            check("tbl_rsp_res", bus.rsp_res, tbl[v].res);
            check("tbl_rsp_flags", bus.rsp_flags, tbl[v].flags);
        end

        // All requesters held valid: grant order 0,1,2,3,0, one response per grant
        do_reset();
        @(posedge clk); #1;
        load_all();
        bus.rsp_ready = 1'b1;
        grants.delete();
        rids.delete();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.rsp_valid && bus.rsp_ready && rids.size() < 5) begin
                id = int'(bus.rsp_id);
                rids.push_back(id);
                if (id < NREQ)
                    check("rr_rsp_data", {bus.rsp_res, bus.rsp_flags},
                          alu_fn(t_opa[id], t_opb[id], t_cin[id], t_mode[id], t_cmd[id]));
            end
            if ((|bus.req_ready) && grants.size() < 5) grants.push_back(oh_idx(bus.req_ready));
            if (rids.size() == 5) break;
        end
        check("rr_rsp_count", rids.size(), 5);
        for (int k = 0; k < 5; k++) begin
            check("rr_grant_order", grants[k], rr_exp[k]);
            check("rr_rsp_order", rids[k], rr_exp[k]);
        end

        // Response stalled 5 cycles, then back-to-back accept with the response transfer
        do_reset();
        @(posedge clk); #1;
        load_all();
        bus.rsp_ready = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
        end
        check("stall_rsp_seen", bus.rsp_valid, 1);
        snap = {bus.rsp_id, bus.rsp_res, bus.rsp_flags};
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("stall_valid", bus.rsp_valid, 1);
            check("stall_fields", {bus.rsp_id, bus.rsp_res, bus.rsp_flags}, snap);
            check("stall_no_ready", bus.req_ready, 0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("b2b_rsp_xfer", {bus.rsp_valid, bus.rsp_id, bus.rsp_res, bus.rsp_flags}, {1'b1, snap});
        check("b2b_req_ready", bus.req_ready, 4'b0010);
        @(negedge clk);
        check("b2b_next_ce", bus.alu_ce, 1);

        // Reset asserted while waiting on the ALU
        do_reset();
        @(posedge clk); #1;
        t_val[1] = 1'b1; t_opa[1] = 8'h12; t_opb[1] = 8'h34; t_cmd[1] = 4'h0;
        t_cin[1] = 1'b1; t_mode[1] = 1'b1;
        drive_bus();
        bus.rsp_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.req_ready[1]) break;
        end
        check("rstw_accept", bus.req_ready, 4'b0010);
        @(posedge clk); #1;
        t_val[1] = 1'b0; t_val[3] = 1'b1;
        drive_bus();
        @(negedge clk);
        @(negedge clk);
        check("rstw_in_wait", {bus.alu_ce, bus.rsp_valid, bus.alu_opa}, {2'b00, 8'h12});
        #1 rst = 1'b0;
        #1 check("rstw_outputs", outs(), 64'd0);
        t_val[3] = 1'b0;
        drive_bus();
        @(negedge clk);
        rst = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) stale = 1'b1;
        end
        check("rstw_no_stale", stale, 0);

        // Randomized traffic against a transaction-level model
        do_reset();
        exp_q.delete();
        acc = '0; hold_prev = 1'b0; held = '0;
        begin
            int   ptr_m;
            logic busy_m;
            ptr_m  = NREQ - 1;
            busy_m = 1'b0;
            for (int cyc = 0; cyc < NRAND; cyc++) begin
                quiet = (cyc >= NRAND - 40);
                @(posedge clk); #1;
                for (int i = 0; i < NREQ; i++) begin
                    if (quiet) t_val[i] = 1'b0;
                    else if (t_val[i] && !acc[i]) begin
                        if ($urandom_range(7) == 0) t_val[i] = 1'b0;
                    end else begin
                        t_val[i]  = ($urandom_range(2) == 0);
                        t_opa[i]  = 8'($urandom);
                        t_opb[i]  = 8'($urandom);
                        t_cin[i]  = 1'($urandom);
                        t_mode[i] = 1'($urandom);
                        t_cmd[i]  = 4'($urandom);
                    end
                end
                bus.rsp_ready = quiet ? 1'b1 : ($urandom_range(3) != 0);
                drive_bus();
                @(negedge clk);
                rsp_x = bus.rsp_valid & bus.rsp_ready;
                if (hold_prev)
                    check("rnd_rsp_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_res, bus.rsp_flags}, {1'b1, held});
                hold_prev = bus.rsp_valid & !bus.rsp_ready;
                held = {bus.rsp_id, bus.rsp_res, bus.rsp_flags};
                if (rsp_x) begin
                    check("rnd_rsp_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0)
                        check("rnd_rsp", {bus.rsp_id, bus.rsp_res, bus.rsp_flags}, exp_q.pop_front());
                end
                allowed = !busy_m || rsp_x;
                win = -1;
                if (allowed) begin
                    for (int k = 1; k <= NREQ; k++) begin
                        if (t_val[(ptr_m + k) % NREQ]) begin
                            win = (ptr_m + k) % NREQ;
                            break;
                        end
                    end
                end
                exp_rdy = '0;
                if (win >= 0) exp_rdy[win] = 1'b1;
                check("rnd_ready", bus.req_ready, exp_rdy);
                if (win >= 0) begin
                    ptr_m  = win;
                    busy_m = 1'b1;
                    exp_q.push_back({3'(win), alu_fn(t_opa[win], t_opb[win], t_cin[win], t_mode[win], t_cmd[win])});
                end else if (rsp_x) begin
                    busy_m = 1'b0;
                end
                acc = bus.req_ready;
            end
        end
        check("rnd_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one ALU; legal range 2..8.
REQ-002 Parameter ALU_LAT, default 1: cycles from the ALU ce-high sampling edge to valid result; legal range 1..4.
REQ-003 Port clk  in  1  sole clock; all logic on its rising edge.
REQ-004 Port rst  in  1  reset; asynchronous assert, active-low, synchronous deassert in the system.
REQ-005 Port req_valid  in  NREQ  per-requester operation valid.
REQ-006 Port req_ready  out  NREQ  per-requester accept; one-hot or zero.
REQ-007 Port req_opa, req_opb  in  NREQ*8 each  packed operands; slice i belongs to requester i.
REQ-008 Port req_cin, req_mode  in  NREQ each  per-requester carry-in and mode.
REQ-009 Port req_cmd  in  NREQ*4  per-requester command.
REQ-010 Port rsp_valid  out  1  response valid.
REQ-011 Port rsp_ready  in  1  response accept.
REQ-012 Port rsp_id  out  3  index of the requester that owns the response.
REQ-013 Port rsp_res  out  9  captured ALU result.
REQ-014 Port rsp_flags  out  6  captured {oflow,cout,g,e,l,err}.
REQ-015 Ports alu_opa/alu_opb (8), alu_cin, alu_ce, alu_mode (1), alu_cmd (4)  out  drive the ALU.
REQ-016 Ports alu_res (9), alu_oflow, alu_cout, alu_g, alu_e, alu_l, alu_err (1)  in  ALU results.

Function
REQ-017 Transfer on a request channel occurs when req_valid[i] and req_ready[i] are both high; transfer on the response channel occurs when rsp_valid and rsp_ready are both high.
REQ-018 FSM states: IDLE, ISSUE, WAIT, RESP; one operation in flight at a time.
REQ-019 IDLE: when any req_valid is high, assert req_ready for the round-robin winner in the same cycle, latch its fields and id, then go to ISSUE.
REQ-020 Round-robin: search starts at last-granted index +1, modulo NREQ; pointer updates only on a request transfer; pointer resets to NREQ-1 so requester 0 wins first.
REQ-021 ISSUE: drive latched operands, cin, mode, cmd and alu_ce=1 for exactly one cycle, then go to WAIT.
REQ-022 WAIT: hold alu_ce=0 and hold alu_* operand outputs stable; count ALU_LAT cycles, capture the ALU result and flags into the response register on the final count, then go to RESP.
REQ-023 RESP: hold rsp_valid=1 with id, res and flags stable until rsp_ready is high; on transfer go to IDLE.
REQ-024 Back-to-back: a request transfer is permitted in the same cycle as a response transfer (RESP -> ISSUE directly) with no bubble.
REQ-025 Requests are never accepted in ISSUE or WAIT, or in RESP without a simultaneous response transfer.
REQ-026 req_valid deasserting before transfer is legal; the arbiter does not retain such a request.
REQ-027 rsp_id is zero-extended from the grant index.

Reset
REQ-028 On rst low (asynchronous): state=IDLE; req_ready=0; rsp_valid=0; rsp_id/res/flags=0; alu_ce=0; alu_opa/opb/cmd/cin/mode=0; latency counter=0; RR pointer=NREQ-1.
REQ-029 Reset mid-operation discards the in-flight operation; no response is produced for it after reset release.

Structure
REQ-030 Shared package alu_pkg SHALL hold: the state enum type; a packed ALU request struct {opa,opb,cin,mode,cmd}; a flags struct {oflow,cout,g,e,l,err}; and the constants DATA_W=8, CMD_W=4, RES_W=9.
REQ-031 Round-robin arbitration SHALL be implemented as a sub-module rr_arbiter (inputs: request vector, pointer; output: one-hot grant).

Verification
REQ-032 Single request: requester 2 sends OPA=8'h0F, OPB=8'h01, ADD, with rsp_ready=1 -> alu_ce high for one cycle, then rsp_valid after ALU_LAT cycles with rsp_id=2, rsp_res=9'h010.
REQ-033 All four requesters held valid continuously -> grants ordered 0,1,2,3,0 with one response per grant.
REQ-034 rsp_ready held low 5 cycles -> rsp_valid and fields stable for all 5 cycles; all req_ready=0 during that time.
REQ-035 Back-to-back: a pending request with rsp_ready=1 in RESP -> request and response transfer in the same cycle; the next alu_ce follows one cycle later.
REQ-036 Assert rst in WAIT -> all outputs reach their reset values immediately; after release, no stale rsp_valid appears.
REQ-037 ALU_LAT=3 build: result captured exactly 3 cycles after the alu_ce sampling edge; ALU errors (err=1) are forwarded unchanged in rsp_flags.
